req_arbiter9: RTL and testbench
===============================

Name: req_arbiter9

Overview:
- Arbiter sharing one downstream resource among 9 requesters; input vector has the same 9-bit request layout as the team's 9-to-4 priority encoder.
- Issues a registered one-hot grant and a 4-bit grant code in the encoder's numbering: req[i] maps to code i+1, and 0 means none.
- Supports fixed-priority (highest index wins, identical to the encoder) or round-robin, plus forced revocation of over-long holds.

Parameters:
- MAX_HOLD, 16: max consecutive grant cycles before forced revoke; 0 disables the timeout.
- HOLD_W, 5: hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 9: request lines; req[i] held high while requester i wants the resource.
- rel, input, 1: owner release strobe; ignored when busy=0.
- fixed_pri, input, 1: 1 = fixed priority (req[8] highest), 0 = round-robin; sampled only in IDLE.
- gnt, output, 9: registered one-hot grant, all-zero when idle.
- code, output, 4: registered grant code; 4'b0001..4'b1001 for gnt[0]..gnt[8], 4'b0000 when no grant.
- busy, output, 1: 1 while a grant is active.
- timeout, output, 1: one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, code=0, busy=0, timeout=0, hold count=0, state=IDLE, round-robin pointer=8 (so the first RR search starts at index 0). Reset overrides everything, including mid-grant; the grant drops on the next edge with no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select a winner and go to GRANT. gnt/code/busy become valid on the next edge (1-cycle latency from req to gnt).
  - If req == 0, stay in IDLE; outputs remain 0.
- Winner selection:
  - fixed_pri=1: highest set index.
  - fixed_pri=0: first set index scanning upward from pointer+1, wrapping 8 to 0. The scan includes the pointer index itself last, so a sole requester is always granted again.
  - The pointer loads the winner index on every grant, in both modes.
- GRANT:
  - The hold count is 1 in the first grant cycle and increments each cycle.
  - End conditions, evaluated each cycle:
    - (a) rel=1;
    - (b) req[owner]=0;
    - (c) MAX_HOLD != 0, hold count == MAX_HOLD, and neither (a) nor (b).
  - On any end condition, go to IDLE at the next edge: gnt=0, code=0, busy=0, hold count=0.
  - timeout=1 for exactly that following cycle, only for (c).
  - Release and timeout in the same cycle are treated as a release, with no timeout pulse.
- Re-arbitration: there is always exactly one idle cycle (busy=0) between consecutive grants. Pending requests are re-evaluated in that IDLE cycle.
- Request changes: requests from non-owners during GRANT are ignored until IDLE.
- Output integrity: code always equals the encoding of gnt; gnt is never multi-hot; no combinational path from req to any output.
- Timed-out owner: if it still holds req, it competes normally. In RR mode it ranks last because of the pointer; in fixed mode it may win again.

Decomposition:
- Shared include file holds:
  - request count (9);
  - code constants CODE_NONE=4'b0000 … CODE_REQ8=4'b1001;
  - state encodings IDLE/GRANT.
- One natural sub-module, rr_pick9 (combinational): takes req, pointer and fixed_pri; returns winner index and valid.
  - Its fixed-priority path matches the 9-to-4 encoder mapping.
  - Instantiated once in the arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 → gnt=0, code=0000, busy=0 throughout.
- Fixed priority:
  - fixed_pri=1, req=9'b100000101 → next cycle gnt=9'b100000000, code=1001.
  - Drop req[8] → IDLE one cycle, then gnt=9'b000000100, code=0011.
- Round-robin rotation: fixed_pri=0, req=9'b000010011 held, owner pulses rel after 2 grant cycles each time → grant order code 0001, 0010, 0101, 0001, with busy=0 for one cycle between grants.
- Timeout:
  - MAX_HOLD=4, req[3] held, no rel → gnt[3] high for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle.
  - With req[6] also pending in RR mode, next grant code=0111.
- Simultaneous release and timeout: rel=1 in the 4th grant cycle (MAX_HOLD=4) → grant drops, timeout stays 0.
- Reset mid-grant: assert rst while gnt[5]=1 → next edge gnt=0, code=0000, timeout=0, pointer=8. With req=9'b111111111 afterwards in RR mode, the first grant is code 0001.

Source files
------------

// File: rtl/req_arbiter9_pkg.sv
// Shared constants, state encoding and helpers for the 9-way request arbiter.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package req_arbiter9_pkg;

    localparam int NUM_REQ = 9;
    localparam int IDX_W   = 4;

    // Grant codes follow the 9-to-4 priority encoder numbering: req[i] -> i+1.
    localparam logic [3:0] CODE_NONE = 4'b0000;
    localparam logic [3:0] CODE_REQ0 = 4'b0001;
    localparam logic [3:0] CODE_REQ1 = 4'b0010;
    localparam logic [3:0] CODE_REQ2 = 4'b0011;
    localparam logic [3:0] CODE_REQ3 = 4'b0100;
    localparam logic [3:0] CODE_REQ4 = 4'b0101;
    localparam logic [3:0] CODE_REQ5 = 4'b0110;
    localparam logic [3:0] CODE_REQ6 = 4'b0111;
    localparam logic [3:0] CODE_REQ7 = 4'b1000;
    localparam logic [3:0] CODE_REQ8 = 4'b1001;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [3:0] idx_to_code(input logic [IDX_W-1:0] idx);
        return idx + 4'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/req_arbiter9_rr_pick9.sv
// Winner selection for 9 requesters: fixed priority (highest index) or round-robin after ptr.
// Latency: purely combinational.
// Backpressure: none; vld simply reflects whether any request is present.
module rr_pick9
    import req_arbiter9_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               fixed_pri,
    output logic [IDX_W-1:0]   win,
    output logic               vld
);

    // Later loop iterations overwrite earlier ones, so iteration order sets priority.
    always_comb begin
        logic [IDX_W:0] sum;
        win = '0;
        vld = |req;
        sum = '0;
        if (fixed_pri) begin
            // Ascending scan: the highest set index is the last to write win.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) win = IDX_W'(i);
            end
        end else begin
            // Descending distance: the nearest index after ptr writes last; ptr itself ranks last.
            for (int k = NUM_REQ; k >= 1; k--) begin
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
                if (req[sum[IDX_W-1:0]]) win = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/req_arbiter9.sv
// Arbiter granting one downstream resource to one of 9 requesters, with hold-time revocation.
// Latency: 1 cycle from req to registered gnt/code; one idle cycle between consecutive grants.
// Backpressure: owner holds the grant until rel, dropping req, or forced timeout after MAX_HOLD cycles.
module req_arbiter9
    import req_arbiter9_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rel,
    input  logic               fixed_pri,
    output logic [NUM_REQ-1:0] gnt,
    output logic [3:0]         code,
    output logic               busy,
    output logic               timeout
);

    localparam bit                TO_EN      = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [3:0]         code_n;
    logic               busy_n, timeout_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   own_idx, own_n;
    logic [IDX_W-1:0]   pick_win;
    logic               pick_vld;

    rr_pick9 u_pick (
        .req       (req),
        .ptr       (ptr),
        .fixed_pri (fixed_pri),
        .win       (pick_win),
        .vld       (pick_vld)
    );

    // Next-state and next-output logic; a release or dropped request masks the timeout.
    always_comb begin
        logic rel_end, drop_end, hold_end;
        state_n   = state;
        gnt_n     = gnt;
        code_n    = code;
        busy_n    = busy;
        timeout_n = 1'b0;
        hold_n    = hold_cnt;
        ptr_n     = ptr;
        own_n     = own_idx;
        rel_end   = rel;
        drop_end  = !req[own_idx];
        hold_end  = TO_EN && (hold_cnt == HOLD_LIMIT);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = GRANT;
                    gnt_n   = idx_to_onehot(pick_win);
                    code_n  = idx_to_code(pick_win);
                    busy_n  = 1'b1;
                    hold_n  = HOLD_W'(1);
                    ptr_n   = pick_win;
                    own_n   = pick_win;
                end
            end
            GRANT: begin
                if (rel_end || drop_end || hold_end) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    code_n    = CODE_NONE;
                    busy_n    = 1'b0;
                    hold_n    = '0;
                    timeout_n = !rel_end && !drop_end;
                end else if (hold_cnt != '1) begin
                    // Saturate so an unbounded hold (timeout disabled) never wraps.
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; synchronous reset overrides any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            code     <= CODE_NONE;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            own_idx  <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            code     <= code_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
            hold_cnt <= hold_n;
            ptr      <= ptr_n;
            own_idx  <= own_n;
        end
    end

endmodule

// File: tb/tb_req_arbiter9.sv
// Directed bench for req_arbiter9 with MAX_HOLD=4.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: not applicable.
module tb_req_arbiter9;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] req;
    logic       rel;
    logic       fixed_pri;
    logic [8:0] gnt;
    logic [3:0] code;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_arbiter9 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .fixed_pri (fixed_pri),
        .gnt       (gnt),
        .code      (code),
        .busy      (busy),
        .timeout   (timeout)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [8:0] e_gnt, input logic [3:0] e_code,
                              input logic e_busy, input logic e_to);
        checks++;
        assert (gnt === e_gnt) else begin
            failures++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
        end
        checks++;
        assert (code === e_code) else begin
            failures++;
            $error("FAIL %s code observed=%b expected=%b", tag, code, e_code);
        end
        checks++;
        assert (busy === e_busy) else begin
            failures++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, e_busy);
        end
        checks++;
        assert (timeout === e_to) else begin
            failures++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, e_to);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_codes [4];
        rr_codes = '{4'b0001, 4'b0010, 4'b0101, 4'b0001};

        rst = 1'b1; req = '0; rel = 1'b0; fixed_pri = 1'b1;

        // Reset then idle
        step(); expect_out("reset_c1", 9'b0, 4'b0000, 1'b0, 1'b0);
        step(); expect_out("reset_c2", 9'b0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(); expect_out("idle_noreq", 9'b0, 4'b0000, 1'b0, 1'b0);

        // Fixed priority: highest index wins, then next highest after an idle cycle
        req = 9'b100000101;
        step(); expect_out("fixed_req8", 9'b100000000, 4'b1001, 1'b1, 1'b0);
        req = 9'b000000101;
        step(); expect_out("fixed_drop_idle", 9'b0, 4'b0000, 1'b0, 1'b0);
        step(); expect_out("fixed_req2", 9'b000000100, 4'b0011, 1'b1, 1'b0);
        req = '0;
        step(); expect_out("fixed_end", 9'b0, 4'b0000, 1'b0, 1'b0);

        // Round-robin rotation from a fresh pointer, releasing after 2 grant cycles
        do_reset();
        fixed_pri = 1'b0;
        req = 9'b000010011;
        for (int n = 0; n < 4; n++) begin
            step(); expect_out($sformatf("rr_g%0d_c1", n), gnt, rr_codes[n], 1'b1, 1'b0);
            checks++;
            assert (code === rr_codes[n]) else begin
                failures++;
                $error("FAIL rr_order%0d code observed=%b expected=%b", n, code, rr_codes[n]);
            end
            step(); expect_out($sformatf("rr_g%0d_c2", n), 9'b1 << (rr_codes[n] - 4'd1),
                               rr_codes[n], 1'b1, 1'b0);
            rel = 1'b1;
            step(); expect_out($sformatf("rr_gap%0d", n), 9'b0, 4'b0000, 1'b0, 1'b0);
            rel = 1'b0;
        end
        req = '0;
        step(); expect_out("rr_end", 9'b0, 4'b0000, 1'b0, 1'b0);

        // Timeout: req[3] held with req[6] pending, pointer at 0
        req = 9'b001001000;
        for (int c = 1; c <= 4; c++) begin
            step(); expect_out($sformatf("hold_c%0d", c), 9'b000001000, 4'b0100, 1'b1, 1'b0);
        end
        step(); expect_out("timeout_pulse", 9'b0, 4'b0000, 1'b0, 1'b1);
        step(); expect_out("after_to_req6", 9'b001000000, 4'b0111, 1'b1, 1'b0);
        req = '0;
        step(); expect_out("req6_drop", 9'b0, 4'b0000, 1'b0, 1'b0);

        // Release coincident with the final hold cycle: no timeout pulse
        fixed_pri = 1'b1;
        req = 9'b000000010;
        for (int c = 1; c <= 3; c++) begin
            step(); expect_out($sformatf("relto_c%0d", c), 9'b000000010, 4'b0010, 1'b1, 1'b0);
        end
        step(); expect_out("relto_c4", 9'b000000010, 4'b0010, 1'b1, 1'b0);
        rel = 1'b1;
        step(); expect_out("relto_notimeout", 9'b0, 4'b0000, 1'b0, 1'b0);
        rel = 1'b0;
        req = '0;
        step(); expect_out("relto_idle", 9'b0, 4'b0000, 1'b0, 1'b0);

        // Reset mid-grant restores the pointer so a full request set grants req[0] first
        fixed_pri = 1'b0;
        req = 9'b000100000;
        step(); expect_out("mid_g5", 9'b000100000, 4'b0110, 1'b1, 1'b0);
        rst = 1'b1;
        req = 9'b111111111;
        step(); expect_out("mid_reset", 9'b0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(); expect_out("post_reset_rr", 9'b000000001, 4'b0001, 1'b1, 1'b0);
        req = '0;
        step(); expect_out("final_idle", 9'b0, 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
